// File: rtl/branch_sequencer.sv
// branch_sequencer: runs the T3-T6 execute steps of a conditional branch.
// Drives the datapath strobes that feed the CON flip-flop and captures the
// CON result. PC is loaded with PC+C only when the condition holds. The
// start/done handshake faces the main control sequencer.
// Optional feature: define BRANCH_STATS_EN to add the branch statistics
// counters Br_Count and Br_Taken_Count, which are STAT_W bits wide.
module branch_sequencer #(
  parameter logic [4:0] OPCODE_BR = 5'b10010,
  parameter int         STAT_W    = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Start,
  input  logic [4:0]        IR_Opcode,
  input  logic              CON_Out,
  output logic              Gra,
  output logic              Rout,
  output logic              CON_In,
  output logic              PCout,
  output logic              Yin,
  output logic              Cout,
  output logic              ADD,
  output logic              Zin,
  output logic              Zlowout,
  output logic              PCin,
  output logic              Busy,
  output logic              Done,
  output logic              Taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] Br_Count,
  output logic [STAT_W-1:0] Br_Taken_Count
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4,
    FIN  = 3'd5,
    REJ  = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic   cond_q;

  // State register; clear drops straight back to IDLE and aborts any branch.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the CON result on the edge that enters T6 (three cycles after CON_In).
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                cond_q <= 1'b0;
    else if (state_q == T5)   cond_q <= CON_Out;
  end

  // Taken: cleared when a Start is accepted, set from cond in FIN, forced low in REJ.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                          Taken <= 1'b0;
    else if (state_q == IDLE && Start)  Taken <= 1'b0;
    else if (state_q == FIN)            Taken <= cond_q;
    else if (state_q == REJ)            Taken <= 1'b0;
  end

  // Next-state logic and Moore strobe decode.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    Gra     = 1'b0;
    Rout    = 1'b0;
    CON_In  = 1'b0;
    PCout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ADD     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    Busy    = (state_q != IDLE);
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) state_d = (IR_Opcode == OPCODE_BR) ? T3 : REJ;
      end
      T3: begin
        Gra     = 1'b1;
        Rout    = 1'b1;
        CON_In  = 1'b1;
        state_d = T4;
      end
      T4: begin
        PCout   = 1'b1;
        Yin     = 1'b1;
        state_d = T5;
      end
      T5: begin
        Cout    = 1'b1;
        ADD     = 1'b1;
        Zin     = 1'b1;
        state_d = T6;
      end
      T6: begin
        Zlowout = cond_q;
        PCin    = cond_q;
        state_d = FIN;
      end
      FIN: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      REJ: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BRANCH_STATS_EN
  // Branch statistics: one count per completed branch, plus one per taken branch; both wrap.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      Br_Count       <= '0;
      Br_Taken_Count <= '0;
    end else if (state_q == FIN) begin
      Br_Count <= Br_Count + 1'b1;
      if (cond_q) Br_Taken_Count <= Br_Taken_Count + 1'b1;
    end
  end
`endif

endmodule
